risc16_uart_tx_mmio: RTL

Memory-mapped UART transmitter on the risc16f data port, downstream of the core's EX-stage load/store interface. It decodes the core's data address, accepts stored bytes into a TX FIFO, and serialises them as 8N1 frames on txd. Its read path is combinational, so loads complete in the same cycle the core presents daddr/doe. Outside its address window it is inert, so RAM and this block share the port via sel.

---
 rtl/risc16_uart_pkg.sv | 11 +
 rtl/risc16_uart_tx_mmio_sync_fifo.sv | 38 +++
 rtl/risc16_uart_tx_mmio.sv | 109 ++++++++++
 3 files changed

// File: rtl/risc16_uart_pkg.sv
// risc16_uart_pkg: register offsets, STATUS bit layout and TX FSM states for the risc16 UART.
package risc16_uart_pkg;
   localparam logic [1:0] TXDATA_OFS  = 2'd0;
   localparam logic [1:0] STATUS_OFS  = 2'd1;
   localparam logic [1:0] BAUDDIV_OFS = 2'd2;
   localparam int ST_BUSY  = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_EMPTY = 2;
   localparam int ST_OVF   = 3;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
endpackage

// File: rtl/risc16_uart_tx_mmio_sync_fifo.sv
// sync_fifo: power-of-two FIFO; a push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic do_push, do_pop;
   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rp];
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + AW'(1);
         if (do_pop) rp <= rp + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push) mem[wp] <= din;
endmodule

// File: rtl/risc16_uart_tx_mmio.sv
// risc16_uart_tx_mmio: memory-mapped 8N1 UART transmitter on the risc16f data port.
// Combinational read path so loads complete in the cycle daddr/doe are presented.
module risc16_uart_tx_mmio
   import risc16_uart_pkg::*;
#(
   parameter logic [15:0] BASE        = 16'hFF00,
   parameter int          DEPTH       = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr,
   input  logic [15:0] din,
   input  logic        oe,
   input  logic        we,
   output logic [15:0] dout,
   output logic        sel,
   output logic        txd,
   output logic        irq
);
   localparam int CW = $clog2(DEPTH) + 1;
   uart_tx_state_t state;
   logic [1:0] ofs;
   logic wr, push, pop, full, empty, ovf, bit_end;
   logic [7:0] f_dout, shift;
   logic [CW-1:0] f_count;
   logic [15:0] baud_div, cur_div, bit_cnt, status;
   logic [2:0] bit_idx;
   assign ofs     = addr[2:1];
   assign sel     = addr[15:3] == BASE[15:3] && ofs != 2'b11;
   assign wr      = we && sel;
   assign push    = wr && ofs == TXDATA_OFS;
   assign bit_end = bit_cnt == cur_div;
   assign pop     = !empty && (state == IDLE || (state == STOP && bit_end));
   assign irq     = empty && state == IDLE;
   always_comb begin
      status           = '0;
      status[ST_BUSY]  = state != IDLE;
      status[ST_FULL]  = full;
      status[ST_EMPTY] = empty;
      status[ST_OVF]   = ovf;
      status[15:8]     = 8'(f_count);
   end
   assign dout = !(sel && oe) ? 16'h0 :
                 ofs == STATUS_OFS  ? status :
                 ofs == BAUDDIV_OFS ? baud_div : 16'h0;
   sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din[7:0]),
      .dout(f_dout), .count(f_count), .full(full), .empty(empty)
   );
   // Overflow set takes priority over a simultaneous clear.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         ovf      <= 1'b0;
         baud_div <= DEFAULT_DIV;
      end else begin
         if (push && full && !pop) ovf <= 1'b1;
         else if (wr && ofs == STATUS_OFS && din[ST_OVF]) ovf <= 1'b0;
         if (wr && ofs == BAUDDIV_OFS) baud_div <= din;
      end
   // cur_div latches baud_div at each bit boundary so divisor writes never stretch the current bit.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state   <= IDLE;
         txd     <= 1'b1;
         shift   <= '0;
         bit_cnt <= '0;
         cur_div <= '0;
         bit_idx <= '0;
      end else if (state == IDLE) begin
         if (!empty) begin
            shift   <= f_dout;
            txd     <= 1'b0;
            state   <= START;
            bit_cnt <= '0;
            cur_div <= baud_div;
         end
      end else if (!bit_end) begin
         bit_cnt <= bit_cnt + 16'd1;
      end else begin
         bit_cnt <= '0;
         cur_div <= baud_div;
         case (state)
            START: begin
               txd     <= shift[0];
               bit_idx <= '0;
               state   <= DATA;
            end
            DATA:
               if (bit_idx == 3'd7) begin
                  txd   <= 1'b1;
                  state <= STOP;
               end else begin
                  shift   <= shift >> 1;
                  txd     <= shift[1];
                  bit_idx <= bit_idx + 3'd1;
               end
            STOP:
               if (!empty) begin
                  shift <= f_dout;
                  txd   <= 1'b0;
                  state <= START;
               end else begin
                  state <= IDLE;
               end
            default: state <= IDLE;
         endcase
      end
endmodule
